// File: rtl/route_read_ctrl.sv
// route_read_ctrl: drains the route FIFO in bursts onto a valid/ready stream, hiding the 1-cycle read latency.
// Define ROUTE_READ_PERF_EN to build the perf_stall counter; otherwise perf_stall is tied to 0.
module route_read_ctrl #(
    parameter int WIDTH      = 128,
    parameter int ADDR_BITS  = 10,
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_BITS:0]    burst_len,
    input  logic [FRAME_BITS-1:0] burst_num,
    output logic [ADDR_BITS:0]    M_count,
    input  logic                  M_Ready,
    output logic                  rd_en,
    input  logic [WIDTH-1:0]      fifo_dout,
    input  logic                  fifo_empty,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           perf_stall
);
    localparam int PW = ADDR_BITS + 1 + FRAME_BITS;
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, BURST = 2'd2, DRAIN = 2'd3;

    logic [1:0]            state_q, state_d, hold_q, hold_d;
    logic [ADDR_BITS:0]    len_q, len_d, beats_q, beats_d;
    logic [FRAME_BITS-1:0] num_q, num_d, bursts_q, bursts_d;
    logic                  inflight_q, inflight_d, zdone_q, zdone_d;
    logic [WIDTH-1:0]      buf_q [4];
    logic [WIDTH-1:0]      buf_d [4];
    logic [1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]            occ_q, occ_d;
    logic [PW-1:0]         emit_q, emit_d, total;
    logic                  go, accept;

    always_comb begin
        go         = state_q == IDLE && start && burst_len != '0 && burst_num != '0;
        zdone_d    = state_q == IDLE && start && !go;
        total      = PW'(len_q) * PW'(num_q);
        m_valid    = occ_q != 3'd0;
        accept     = m_valid && m_ready;
        m_last     = m_valid && emit_q == total - PW'(1);
        m_data     = m_valid ? buf_q[rptr_q] : '0;
        // occ+inflight bounds everything already committed to the 4-entry buffer
        rd_en      = state_q == BURST && beats_q != '0 && !fifo_empty && (occ_q + 3'(inflight_q)) < 3'd4;
        done       = zdone_q || (state_q == DRAIN && accept && m_last);
        busy       = state_q != IDLE;
        M_count    = len_q;
        inflight_d = rd_en;
        state_d    = state_q;
        len_d      = len_q;
        num_d      = num_q;
        beats_d    = rd_en ? beats_q - (ADDR_BITS+1)'(1) : beats_q;
        bursts_d   = bursts_q;
        hold_d     = hold_q != 2'd0 ? hold_q - 2'd1 : hold_q;
        emit_d     = go ? '0 : accept ? emit_q + PW'(1) : emit_q;
        if (go) begin
            state_d  = WAIT;
            len_d    = burst_len;
            num_d    = burst_num;
            beats_d  = burst_len;
            bursts_d = burst_num;
            hold_d   = 2'd0;
        end
        if (state_q == WAIT && M_Ready && hold_q == 2'd0) state_d = BURST;
        // M_Ready lags our reads by 2 cycles, so hold off before trusting it again
        if (state_q == BURST && beats_d == '0) begin
            state_d  = bursts_q > FRAME_BITS'(1) ? WAIT : DRAIN;
            bursts_d = bursts_q - FRAME_BITS'(1);
            beats_d  = len_q;
            hold_d   = 2'd2;
        end
        if (state_q == DRAIN && accept && m_last) state_d = IDLE;
        buf_d = buf_q;
        if (inflight_q) buf_d[wptr_q] = fifo_dout;
        wptr_d = wptr_q + 2'(inflight_q);
        rptr_d = rptr_q + 2'(accept);
        occ_d  = occ_q + 3'(inflight_q) - 3'(accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            len_q      <= '0;
            beats_q    <= '0;
            num_q      <= '0;
            bursts_q   <= '0;
            inflight_q <= 1'b0;
            zdone_q    <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            emit_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            len_q      <= len_d;
            beats_q    <= beats_d;
            num_q      <= num_d;
            bursts_q   <= bursts_d;
            inflight_q <= inflight_d;
            zdone_q    <= zdone_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
            emit_q     <= emit_d;
        end
    end

    always_ff @(posedge clk) buf_q <= buf_d;

`ifdef ROUTE_READ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb perf_d = go ? '0 : (state_q == BURST && beats_q != '0 && !rd_en && perf_q != '1) ? perf_q + 32'd1 : perf_q;

    always_ff @(posedge clk) perf_q <= rst ? '0 : perf_d;

    assign perf_stall = perf_q;
`else
    assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_route_read_ctrl.sv
// tb_route_read_ctrl: random-data scoreboard bench with a queue-based FIFO model and decoupled monitor.
module tb_route_read_ctrl;
    localparam int W = 128, AB = 10, FB = 16;
`ifdef ROUTE_READ_PERF_EN
    localparam int PERF_EXP = 5;
`else
    localparam int PERF_EXP = 0;
`endif

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [AB:0] burst_len = '0;
    logic [FB-1:0] burst_num = '0;
    logic M_Ready = 1'b0, fifo_empty = 1'b1, m_ready = 1'b0;
    logic [W-1:0] fifo_dout = '0;
    logic [AB:0] M_count;
    logic rd_en, m_valid, m_last, busy, done;
    logic [W-1:0] m_data;
    logic [31:0] perf_stall;

    route_read_ctrl #(.WIDTH(W), .ADDR_BITS(AB), .FRAME_BITS(FB)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .burst_num(burst_num),
        .M_count(M_count), .M_Ready(M_Ready), .rd_en(rd_en), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .done(done), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    logic [W-1:0] fq[$];
    int checks = 0, errors = 0;
    int mode = 0, force_at = 0, force_cnt = 0;
    bit forced = 1'b0, poking = 1'b0, rd_pend = 1'b0;
    int rd_total = 0, rd_frame = 0, acc_total = 0, done_cnt = 0, outstanding = 0;
    int cyc = 0, last_rd = 0, cur_len = 1;

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, req);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // FIFO and sink environment: pops one cycle after rd_en, M_Ready = count >= M_count
    initial forever begin
        @(negedge clk);
        rd_pend = rd_en && !rst;
        @(posedge clk);
        #1;
        if (rd_pend && fq.size() > 0) fifo_dout = fq.pop_front();
        if (force_cnt > 0) force_cnt--;
        if (force_at > 0 && rd_frame == force_at && !forced) begin
            force_cnt = 5;
            forced = 1'b1;
        end
        fifo_empty = fq.size() == 0 || force_cnt > 0;
        M_Ready = fq.size() >= int'(M_count);
        m_ready = mode == 0 ? 1'b1 : mode == 1 ? !m_ready : mode == 2 ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
    end

    // monitor: pops the scoreboard on every handshake, checks protocol rules each cycle
    initial begin
        beat_t e;
        bit hold = 1'b0;
        logic [W-1:0] hold_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                outstanding = 0;
                rd_frame = 0;
                hold = 1'b0;
            end else begin
                if (start && !poking && burst_len != '0 && burst_num != '0) begin
                    rd_frame = 0;
                    cur_len = int'(burst_len);
                end
                if (rd_en) begin
                    chk1("rd_while_empty", fifo_empty, 1'b0);
                    chki("rd_occ_inflight", outstanding < 4 ? outstanding : 4, outstanding);
                    if (rd_frame > 0 && rd_frame % cur_len == 0) chk1("burst_gap_ge2", (cyc - last_rd) >= 3, 1'b1);
                    rd_frame++;
                    rd_total++;
                    outstanding++;
                    last_rd = cyc;
                end
                if (hold) begin
                    chk1("hold_valid", m_valid, 1'b1);
                    chkw("hold_data", m_data, hold_data);
                end
                chk1("m_last", m_last, m_valid && exp_q.size() > 0 && exp_q[0].last);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) chk1("unexpected_beat", 1'b1, 1'b0);
                    else begin
                        e = exp_q.pop_front();
                        chkw("m_data", m_data, e.data);
                        chk1("done_at_last", done, e.last);
                    end
                    acc_total++;
                    outstanding--;
                end
                if (done) done_cnt++;
                hold = m_valid && !m_ready;
                hold_data = m_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom};
            b.last = i == n - 1;
            fq.push_back(b.data);
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_start(input int len, input int num);
        burst_len = len[AB:0];
        burst_num = num[FB-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        if (done_cnt == d0) chk1("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_frame(input int len, input int num, input int md, input int fa, input bit poke, input bit lat);
        int d0, r0;
        mode = md;
        force_at = fa;
        forced = 1'b0;
        load(len * num);
        d0 = done_cnt;
        r0 = rd_total;
        pulse_start(len, num);
        chk1("busy_after_start", busy, 1'b1);
        if (lat) begin
            tick();
            chk1("first_rd_cycle2", rd_en, 1'b1);
        end
        if (poke) begin
            repeat (3) tick();
            poking = 1'b1;
            pulse_start(2, 2);
            poking = 1'b0;
            chki("m_count_kept", int'(M_count), len);
        end
        wait_done(d0, 3000);
        chk1("busy_fall", busy, 1'b0);
        repeat (3) tick();
        chki("done_once", done_cnt - d0, 1);
        chki("rd_count", rd_total - r0, len * num);
        chki("beats_left", exp_q.size(), 0);
        chki("fifo_drained", fq.size(), 0);
        force_at = 0;
    endtask

    initial begin
        int d0, r0, a0;
        repeat (3) tick();
        chk1("rst_rd_en", rd_en, 1'b0);
        chk1("rst_m_valid", m_valid, 1'b0);
        chk1("rst_m_last", m_last, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chki("rst_m_count", int'(M_count), 0);
        chkw("rst_m_data", m_data, '0);
        chki("rst_perf", int'(perf_stall), 0);
        rst = 1'b0;
        tick();
        run_frame(4, 3, 0, 0, 1'b0, 1'b1);
        run_frame(4, 3, 1, 0, 1'b0, 1'b1);
        run_frame(4, 3, 2, 0, 1'b0, 1'b0);
        run_frame(8, 1, 0, 3, 1'b0, 1'b1);
        chki("perf_stall", int'(perf_stall), PERF_EXP);
        run_frame(4, 3, 0, 0, 1'b0, 1'b0);
        chki("perf_cleared", int'(perf_stall), 0);
        for (int k = 0; k < 2; k++) begin
            d0 = done_cnt;
            r0 = rd_total;
            pulse_start(k == 0 ? 4 : 0, k == 0 ? 0 : 3);
            chk1("zero_done", done, 1'b1);
            chk1("zero_busy", busy, 1'b0);
            repeat (4) tick();
            chki("zero_done_once", done_cnt - d0, 1);
            chki("zero_no_rd", rd_total - r0, 0);
        end
        run_frame(4, 4, 0, 0, 1'b1, 1'b0);
        mode = 0;
        load(16);
        d0 = done_cnt;
        a0 = acc_total;
        pulse_start(4, 4);
        for (int i = 0; i < 200 && acc_total - a0 < 3; i++) tick();
        chk1("rst_test_reached_3", acc_total - a0 >= 3, 1'b1);
        rst = 1'b1;
        fq.delete();
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk1("mid_rst_rd_en", rd_en, 1'b0);
        chk1("mid_rst_m_valid", m_valid, 1'b0);
        chk1("mid_rst_m_last", m_last, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chki("mid_rst_m_count", int'(M_count), 0);
        chkw("mid_rst_m_data", m_data, '0);
        chki("mid_rst_perf", int'(perf_stall), 0);
        repeat (3) tick();
        chki("mid_rst_no_done", done_cnt - d0, 0);
        run_frame(4, 4, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) run_frame($urandom_range(1, 6), $urandom_range(1, 3), 2 + k % 2, 0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
